// File: rtl/phy_pkg.sv
// Shared definitions for the PHY transmit path: idle symbol, lane FSM states and frame sizing.
package phy_pkg;

  localparam logic [7:0] COM_WORD = 8'hBC;

  typedef enum logic [0:0] {
    StTrain = 1'b0,
    StData  = 1'b1
  } phy_tx_state_t;

  function automatic int unsigned frame_bits(input int unsigned lanes, input int unsigned width);
    return lanes * width;
  endfunction

endpackage

// File: rtl/phy_tx_train_ctrl.sv
// Link-training controller: counts all-idle frames after reset or retrain, then opens the link.
module phy_tx_train_ctrl
  import phy_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic boundary,
  input  logic train_req,
  output logic link_up,
  output logic accept_en
);

  localparam int unsigned CntW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;

  phy_tx_state_t   state_q, state_d;
  logic [CntW-1:0] train_cnt_q, train_cnt_d;

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    // State only moves between frames, so a request mid-frame is never seen.
    if (boundary) begin
      unique case (state_q)
        StTrain: begin
          if (train_cnt_q == CntW'(SYNC_COUNT - 1)) begin
            state_d     = StData;
            train_cnt_d = '0;
          end else begin
            train_cnt_d = train_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (train_req) begin
            state_d     = StTrain;
            train_cnt_d = '0;
          end
        end
        default: state_d = StTrain;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StTrain;
      train_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
    end
  end

  assign link_up   = (state_q == StData);
  assign accept_en = boundary && link_up && !train_req;

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Single-clock lane serializer: packs LANES words into one frame and shifts it out a bit per clk.
module phy_tx_lane_serializer
  import phy_pkg::*;
#(
  parameter int unsigned      LANES      = 4,
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(COM_WORD),
  parameter int unsigned      SYNC_COUNT = 4,
  parameter bit               LSB_FIRST  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  input  logic                   train_req,
  output logic                   in_ready,
  output logic                   data_out,
  output logic                   frame_sync,
  output logic                   link_up
);

  localparam int unsigned FrameBits = frame_bits(LANES, WIDTH);
  localparam int unsigned CntW      = $clog2(FrameBits);
  // Every lane carries the same idle word, so lane ordering is irrelevant here.
  localparam logic [FrameBits-1:0] IdleFrame = {LANES{IDLE_WORD}};

  logic [FrameBits-1:0] sr_q, sr_d, next_frame;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 boundary;

  assign boundary = (bit_cnt_q == CntW'(FrameBits - 1));

  phy_tx_train_ctrl #(
    .SYNC_COUNT (SYNC_COUNT)
  ) u_train_ctrl (
    .clk       (clk),
    .reset     (reset),
    .boundary  (boundary),
    .train_req (train_req),
    .link_up   (link_up),
    .accept_en (in_ready)
  );

  // The shift register holds the frame in transmit order: lane 0 sits at the head end, and each
  // word's bits are laid out so that a plain shift walks them in the selected bit order.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned Pos = (LSB_FIRST ? k : (LANES - 1 - k)) * WIDTH;
    assign next_frame[Pos +: WIDTH] = (in_ready && in_valid[k]) ? in_data[k*WIDTH +: WIDTH]
                                                                : IDLE_WORD;
  end

  always_comb begin
    sr_d      = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    bit_cnt_d = bit_cnt_q + CntW'(1);
    if (boundary) begin
      sr_d      = next_frame;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q      <= IdleFrame;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign data_out   = LSB_FIRST ? sr_q[0] : sr_q[FrameBits-1];
  assign frame_sync = (bit_cnt_q == '0);

endmodule
